// File: rtl/tensor_dpu_arbiter.sv
// Shares one tensor DPU among NUM_REQS requesters: round-robin grant, per-requester credits, tag-routed results.
// Optional macro TENSOR_ARB_LOCK_EN keeps a multi-step HMMA instruction back-to-back on the DPU.

module tensor_dpu_arbiter_credit #(
   parameter int MAX_OUTSTANDING = 8,
   parameter int CNTW            = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic dec,
   output logic full,
   output logic nonzero
);
   logic [CNTW-1:0] cnt;

   // Simultaneous issue and return leave the count unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (inc && !dec)
         cnt <= cnt + 1'b1;
      else if (dec && !inc)
         cnt <= cnt - 1'b1;
   end

   assign full    = (cnt == CNTW'(MAX_OUTSTANDING));
   assign nonzero = (cnt != '0);
endmodule

module tensor_dpu_arbiter #(
   parameter int NUM_REQS        = 4,
   parameter int DATAW           = 1536,
   parameter int RSPW            = 512,
   parameter int MAX_OUTSTANDING = 8,
   parameter int TAGW            = $clog2(NUM_REQS),
   parameter int CNTW            = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQS-1:0]            req_valid,
   output logic [NUM_REQS-1:0]            req_ready,
   input  logic [NUM_REQS-1:0]            req_last,
   input  logic [NUM_REQS-1:0][DATAW-1:0] req_data,
   output logic                           dpu_valid,
   input  logic                           dpu_ready,
   output logic [DATAW-1:0]               dpu_data,
   output logic [TAGW-1:0]                dpu_tag,
   input  logic                           rsp_in_valid,
   output logic                           rsp_in_ready,
   input  logic [TAGW-1:0]                rsp_in_tag,
   input  logic [RSPW-1:0]                rsp_in_data,
   output logic [NUM_REQS-1:0]            rsp_valid,
   input  logic [NUM_REQS-1:0]            rsp_ready,
   output logic [RSPW-1:0]                rsp_data,
   output logic                           busy
);
   logic [NUM_REQS-1:0] cnt_full, cnt_nz, eligible, grant, lock_mask;
   logic [NUM_REQS-1:0] rsp_hit, rsp_fire;
   logic [TAGW-1:0]     rr_ptr, grant_idx;
   logic                grant_any, can_load, req_fire, tag_ok;

`ifdef TENSOR_ARB_LOCK_EN
   typedef enum logic {UNLOCKED, LOCKED} lock_state_e;
   lock_state_e     state, state_n;
   logic [TAGW-1:0] owner, owner_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= UNLOCKED;
         owner <= '0;
      end else begin
         state <= state_n;
         owner <= owner_n;
      end
   end

   // While locked only the owner may be granted, even if it is stalled or out of credit.
   always_comb begin
      state_n   = state;
      owner_n   = owner;
      lock_mask = '1;
      case (state)
         UNLOCKED: begin
            if (req_fire && !req_last[grant_idx]) begin
               state_n = LOCKED;
               owner_n = grant_idx;
            end
         end
         LOCKED: begin
            lock_mask        = '0;
            lock_mask[owner] = 1'b1;
            if (req_fire && req_last[grant_idx])
               state_n = UNLOCKED;
         end
         default: state_n = UNLOCKED;
      endcase
   end
`else
   logic unused_last;
   assign unused_last = ^req_last;
   assign lock_mask   = '1;
`endif

   assign eligible = req_valid & ~cnt_full & lock_mask;

   // First eligible requester at or after the round-robin pointer.
   always_comb begin
      int j;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      j         = 0;
      for (int k = 0; k < NUM_REQS; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_REQS)
            j = j - NUM_REQS;
         if (!grant_any && eligible[j]) begin
            grant_any = 1'b1;
            grant_idx = TAGW'(j);
         end
      end
      if (grant_any)
         grant[grant_idx] = 1'b1;
   end

   assign can_load  = !dpu_valid || dpu_ready;
   assign req_ready = can_load ? grant : '0;
   assign req_fire  = grant_any && can_load;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dpu_valid <= 1'b0;
         dpu_data  <= '0;
         dpu_tag   <= '0;
      end else if (can_load) begin
         dpu_valid <= req_fire;
         if (req_fire) begin
            dpu_data <= req_data[grant_idx];
            dpu_tag  <= grant_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rr_ptr <= '0;
      else if (req_fire)
         rr_ptr <= (grant_idx == TAGW'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
   end

   // Results for a requester with no outstanding op (or an out-of-range tag) are swallowed.
   always_comb begin
      rsp_hit = '0;
      for (int i = 0; i < NUM_REQS; i++)
         rsp_hit[i] = (rsp_in_tag == TAGW'(i));
   end

   assign tag_ok       = |(rsp_hit & cnt_nz);
   assign rsp_valid    = rsp_in_valid ? (rsp_hit & cnt_nz) : '0;
   assign rsp_in_ready = tag_ok ? |(rsp_hit & rsp_ready) : 1'b1;
   assign rsp_fire     = rsp_valid & rsp_ready;
   assign rsp_data     = rsp_in_data;

   for (genvar i = 0; i < NUM_REQS; i++) begin : g_credit
      tensor_dpu_arbiter_credit #(
         .MAX_OUTSTANDING (MAX_OUTSTANDING),
         .CNTW            (CNTW)
      ) u_credit (
         .clk     (clk),
         .reset   (reset),
         .inc     (req_fire && grant[i]),
         .dec     (rsp_fire[i]),
         .full    (cnt_full[i]),
         .nonzero (cnt_nz[i])
      );
   end

   assign busy = dpu_valid || (|cnt_nz);

`ifdef RUNTIME_ASSERT
   a_rsp_tag_owned: assert property (@(posedge clk) disable iff (!reset) rsp_in_valid |-> tag_ok)
      else $error("tensor_dpu_arbiter: result tag %0d has no outstanding op", rsp_in_tag);
`endif
endmodule

// File: tb/tb_tensor_dpu_arbiter.sv
// Bench for tensor_dpu_arbiter: queue/array model checked every cycle plus directed literal scenarios.
module tb_tensor_dpu_arbiter;
   localparam int N = 4, DW = 32, RW = 16, MAXO = 8, TW = 2;

   logic                   clk = 1'b0;
   logic                   reset = 1'b0;
   logic [N-1:0]           req_valid, req_ready, req_last, rsp_valid, rsp_ready;
   logic [N-1:0][DW-1:0]   req_data;
   logic                   dpu_valid, dpu_ready, rsp_in_valid, rsp_in_ready, busy;
   logic [DW-1:0]          dpu_data;
   logic [TW-1:0]          dpu_tag, rsp_in_tag;
   logic [RW-1:0]          rsp_in_data, rsp_data;

   int checks = 0, failures = 0;

   tensor_dpu_arbiter #(.NUM_REQS(N), .DATAW(DW), .RSPW(RW), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last), .req_data(req_data),
      .dpu_valid(dpu_valid), .dpu_ready(dpu_ready), .dpu_data(dpu_data), .dpu_tag(dpu_tag),
      .rsp_in_valid(rsp_in_valid), .rsp_in_ready(rsp_in_ready), .rsp_in_tag(rsp_in_tag),
      .rsp_in_data(rsp_in_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: per-requester credit counts, RR pointer, one-entry issue slot.
   int            m_cnt[N];
   int            m_ptr, m_tag, m_owner, g, t;
   bit            m_vld, m_lock, can_load, good, exp_busy;
   logic [DW-1:0] m_data;
   logic [N-1:0]  exp_rdy, exp_rv;
   int            fires[N];
   int            tag_log[$];

   always @(negedge clk) begin
      if (!reset) begin
         check("rst_dpu_valid", dpu_valid, 0);
         check("rst_busy", busy, 0);
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_ptr = 0; m_vld = 0; m_data = '0; m_tag = 0; m_lock = 0; m_owner = 0;
      end else begin
         exp_busy = m_vld;
         foreach (m_cnt[i]) if (m_cnt[i] > 0) exp_busy = 1;
         check("dpu_valid", dpu_valid, m_vld);
         check("dpu_tag", dpu_tag, m_tag);
         check("dpu_data", dpu_data, m_data);
         check("busy", busy, exp_busy);
         g = -1;
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && req_valid[idx] && m_cnt[idx] < MAXO && (!m_lock || idx == m_owner)) g = idx;
         end
         can_load = !m_vld || dpu_ready;
         exp_rdy  = (g >= 0 && can_load) ? (N'(1) << g) : '0;
         check("req_ready", req_ready, exp_rdy);
         t    = int'(rsp_in_tag);
         good = (t < N) && (m_cnt[t] > 0);
         exp_rv = (rsp_in_valid && good) ? (N'(1) << t) : '0;
         check("rsp_valid", rsp_valid, exp_rv);
         check("rsp_in_ready", rsp_in_ready, good ? rsp_ready[t] : 1'b1);
         check("rsp_data", rsp_data, rsp_in_data);
         if (dpu_valid && dpu_ready) tag_log.push_back(int'(dpu_tag));
         for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) fires[i]++;
         // advance model to the state after the coming edge
         if (rsp_in_valid && good && rsp_ready[t]) m_cnt[t]--;
         if (can_load) begin
            m_vld = (g >= 0);
            if (g >= 0) begin m_data = req_data[g]; m_tag = g; end
         end
         if (exp_rdy != 0) begin
            m_cnt[g]++;
            m_ptr = (g + 1) % N;
`ifdef TENSOR_ARB_LOCK_EN
            if (!m_lock && !req_last[g]) begin m_lock = 1; m_owner = g; end
            else if (m_lock && req_last[g]) m_lock = 0;
`endif
         end
      end
   end

   function automatic int sum_fires();
      int s = 0;
      for (int i = 0; i < N; i++) s += fires[i];
      return s;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 0; req_valid = '0; req_last = '0; rsp_in_valid = 0; rsp_in_tag = '0;
      rsp_ready = '0; dpu_ready = 0;
      repeat (2) cyc();
      reset = 1;
   endtask

   task automatic check_log(input string nm, input int base, input int k, input int exp);
      if (base + k < tag_log.size()) check(nm, tag_log[base + k], exp);
      else check(nm, 64'hDEAD, exp);
   endtask

   int exp_rr[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`ifdef TENSOR_ARB_LOCK_EN
   int exp_lock[5] = '{0, 0, 0, 0, 1};
`else
   int exp_lock[5] = '{0, 1, 0, 1, 0};
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int base, f0, steps;
      req_valid = '0; req_last = '0; rsp_in_valid = 0; rsp_in_tag = '0; rsp_ready = '0;
      dpu_ready = 0; rsp_in_data = '0;
      for (int i = 0; i < N; i++) req_data[i] = $urandom;
      do_reset();
      check("reset_dpu_valid", dpu_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_dpu_tag", dpu_tag, 0);
      check("reset_dpu_data", dpu_data, 0);

      // Full load, results returned as soon as the DPU takes the op
      base = tag_log.size(); f0 = sum_fires();
      req_valid = '1; dpu_ready = 1; rsp_ready = '1;
      repeat (9) begin
         rsp_in_valid = dpu_valid; rsp_in_tag = dpu_tag; rsp_in_data = RW'($urandom);
         cyc();
      end
      rsp_in_valid = 0;
      for (int k = 0; k < 8; k++) check_log("rr_tag_seq", base, k, exp_rr[k]);
      check("rr_one_fire_per_cycle", sum_fires() - f0, 9);

      // Credit limit on a lone requester
      do_reset();
      f0 = fires[2];
      req_valid = 4'b0100; dpu_ready = 1;
      repeat (12) cyc();
      check("credit_fires", fires[2] - f0, 8);
      check("credit_blocked", req_ready, 0);
      rsp_in_valid = 1; rsp_in_tag = 2; rsp_ready = '1;
      #1;
      check("credit_rsp_valid", rsp_valid, 4'b0100);
      cyc();
      rsp_in_valid = 0;
      repeat (3) cyc();
      check("credit_refire", fires[2] - f0, 9);

      // DPU back-pressure
      do_reset();
      req_data[0] = 32'hA0A0_0000; req_data[1] = 32'hB1B1_0001;
      req_valid = 4'b0011; dpu_ready = 0;
      cyc();
      repeat (5) begin
         check("stall_req_ready", req_ready, 0);
         check("stall_tag", dpu_tag, 0);
         check("stall_data", dpu_data, 32'hA0A0_0000);
         cyc();
      end
      base = tag_log.size();
      dpu_ready = 1;
      repeat (4) cyc();
      for (int k = 0; k < 4; k++) check_log("stall_resume_tag", base, k, k % 2);

      // Same-cycle issue and return for requester 1
      do_reset();
      f0 = fires[1];
      req_valid = 4'b0010; dpu_ready = 1;
      repeat (3) cyc();
      check("same_pre_fires", fires[1] - f0, 3);
      rsp_in_valid = 1; rsp_in_tag = 1; rsp_ready = 4'b0010;
      #1;
      check("same_req_ready", req_ready, 4'b0010);
      check("same_rsp_valid", rsp_valid, 4'b0010);
      cyc();
      rsp_in_valid = 0;
      repeat (10) cyc();
      check("same_total_fires", fires[1] - f0, 9);

      // Orphan result is dropped
      do_reset();
      rsp_in_valid = 1; rsp_in_tag = 3; rsp_ready = '0;
      #1;
      check("orphan_rsp_in_ready", rsp_in_ready, 1);
      check("orphan_rsp_valid", rsp_valid, 0);
      cyc();
      check("orphan_busy", busy, 0);
      rsp_in_valid = 0;

      // Reset asserted mid-burst
      req_valid = '1; dpu_ready = 1;
      repeat (3) cyc();
      check("burst_busy", busy, 1);
      #2 reset = 0;
      #1;
      check("midrst_dpu_valid", dpu_valid, 0);
      check("midrst_busy", busy, 0);
      cyc();
      req_valid = '0;
      reset = 1;
      cyc();

      // Multi-step instruction from req 0 competing with req 1
      do_reset();
      dpu_ready = 1; req_valid[1] = 1; req_last[1] = 1;
      base = tag_log.size(); steps = 0;
      repeat (12) begin
         req_valid[0] = (steps < 4);
         req_last[0]  = (steps == 3);
         #1;
         if (req_ready[0]) steps++;
         cyc();
      end
      check("lock_steps", steps, 4);
      for (int k = 0; k < 5; k++) check_log("lock_tag_seq", base, k, exp_lock[k]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
